// File: rtl/data_mem_ctrl_if.sv
// Core-side load/store channel: request handshake plus the one-cycle
// response pulse. The core is the master, the controller is the slave.
interface data_mem_ctrl_if;
    logic        valid;
    logic        ready;
    logic        wr;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output valid, wr, size, is_unsigned, addr, wdata,
        input  ready, resp_valid, err, rdata
    );

    modport slave (
        input  valid, wr, size, is_unsigned, addr, wdata,
        output ready, resp_valid, err, rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store front-end: turns byte-addressed byte/half/word requests into
// word-addressed accesses on a single-port synchronous SRAM with a per-bit
// write mask, and returns extended load data or an error as a one-cycle pulse.
// Every output comes straight from a register.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    data_mem_ctrl_if.slave        io_cpu,
    output logic                  o_sram_cs,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [31:0]           o_sram_data,
    output logic [31:0]           o_sram_we,
    input  logic [31:0]           i_sram_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_resp_valid;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic                  r_cs;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [31:0]           r_sram_data;
    logic [31:0]           r_sram_we;
    logic                  r_wr;
    logic                  r_unsigned;
    logic [1:0]            r_size;
    logic [1:0]            r_lane;

    logic                  w_accept;
    logic                  w_err;
    logic [31:0]           w_wdata;
    logic [31:0]           w_mask;
    logic [31:0]           w_shift;
    logic [31:0]           w_load;

    assign w_accept = io_cpu.valid & r_ready;

    // Classify the incoming request: illegal size, misalignment or out-of-range address.
    always_comb begin
        w_err = 1'b0;
        case (io_cpu.size)
            2'b11:   w_err = 1'b1;
            2'b01:   w_err = io_cpu.addr[0];
            2'b10:   w_err = |io_cpu.addr[1:0];
            default: w_err = 1'b0;
        endcase
        if (|io_cpu.addr[31:ADDR_WIDTH+2]) begin
            w_err = 1'b1;
        end
    end

    // Replicate store data across all lanes; the mask picks the lanes that land.
    always_comb begin
        w_wdata = io_cpu.wdata;
        w_mask  = 32'hFFFF_FFFF;
        case (io_cpu.size)
            2'b00: begin
                w_wdata = {4{io_cpu.wdata[7:0]}};
                w_mask  = 32'h0000_00FF << {io_cpu.addr[1:0], 3'b000};
            end
            2'b01: begin
                w_wdata = {2{io_cpu.wdata[15:0]}};
                w_mask  = 32'h0000_FFFF << {io_cpu.addr[1], 4'b0000};
            end
            default: begin
                w_wdata = io_cpu.wdata;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    assign w_shift = i_sram_data >> {r_lane, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]};
            default: w_load = i_sram_data;
        endcase
    end

    // Request sequencer; every output is registered on the state transition that needs it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_cs         <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_data  <= '0;
            r_sram_we    <= '0;
            r_wr         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ready    <= 1'b0;
                        r_wr       <= io_cpu.wr;
                        r_unsigned <= io_cpu.is_unsigned;
                        r_size     <= io_cpu.size;
                        r_lane     <= io_cpu.addr[1:0];
                        if (w_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                        end else begin
                            r_state     <= ACCESS;
                            r_cs        <= 1'b1;
                            r_sram_addr <= io_cpu.addr[ADDR_WIDTH+1:2];
                            r_sram_we   <= io_cpu.wr ? w_mask : 32'h0;
                            if (io_cpu.wr) begin
                                r_sram_data <= w_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    r_cs      <= 1'b0;
                    r_sram_we <= '0;
                    if (r_wr) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_err        <= 1'b0;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_rdata      <= w_load;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_err        <= 1'b0;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    r_cs         <= 1'b0;
                    r_sram_we    <= '0;
                end
            endcase
        end
    end

    assign io_cpu.ready      = r_ready;
    assign io_cpu.resp_valid = r_resp_valid;
    assign io_cpu.err        = r_err;
    assign io_cpu.rdata      = r_rdata;
    assign o_sram_cs         = r_cs;
    assign o_sram_addr       = r_sram_addr;
    assign o_sram_data       = r_sram_data;
    assign o_sram_we         = r_sram_we;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a byte-array reference memory predicts every
// response and every SRAM access; a monitor compares whatever the DUT
// presents against the queued predictions.
module tb_data_mem_ctrl;
    localparam int AW     = 10;
    localparam int NBYTES = 4 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if cpu_if();

    logic          sram_cs;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_we;
    logic [31:0]   sram_rdata;

    data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .io_cpu      (cpu_if),
        .o_sram_cs   (sram_cs),
        .o_sram_addr (sram_addr),
        .o_sram_data (sram_wdata),
        .o_sram_we   (sram_we),
        .i_sram_data (sram_rdata)
    );

    // SRAM behaviour: bit-masked write, registered read, contents survive reset.
    logic [31:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            sram[sram_addr] <= (sram[sram_addr] & ~sram_we) | (sram_wdata & sram_we);
            sram_rdata      <= sram[sram_addr];
        end
    end

    logic [7:0] ref_mem [0:NBYTES-1];

    typedef struct {
        logic        err;
        logic        load;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   we;
        logic [31:0]   data;
    } acc_t;

    resp_t resp_q[$];
    acc_t  acc_q[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Monitor: pop a prediction whenever the DUT responds or touches the SRAM.
    always @(negedge clk) begin
        resp_t r;
        acc_t  a;
        if (rst_n) begin
            if (cpu_if.resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", {31'b0, cpu_if.resp_valid}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_err", {31'b0, cpu_if.err}, {31'b0, r.err});
                    chk("resp_latency", cycle, r.due);
                    chk("ready_in_resp", {31'b0, cpu_if.ready}, 32'd0);
                    if (r.load && !r.err) chk("rdata", cpu_if.rdata, r.rdata);
                end
            end
            if (sram_cs) begin
                chk("ready_in_access", {31'b0, cpu_if.ready}, 32'd0);
                if (acc_q.size() == 0) begin
                    chk("unexpected_sram_cs", {31'b0, sram_cs}, 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    chk("sram_addr", {{(32-AW){1'b0}}, sram_addr}, {{(32-AW){1'b0}}, a.addr});
                    chk("sram_we", sram_we, a.we);
                    if (a.we != 0) chk("sram_data", sram_wdata, a.data);
                end
            end
        end
    end

    // Present one request, wait for acceptance, and queue its predicted outcome.
    // i_valid stays high afterwards so consecutive calls run back to back.
    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        resp_t       r;
        acc_t        a;
        int          n;
        int          base;
        int          guard;
        logic        ok;
        logic [31:0] v;
        cpu_if.valid       = 1'b1;
        cpu_if.wr          = wr;
        cpu_if.size        = size;
        cpu_if.is_unsigned = uns;
        cpu_if.addr        = addr;
        cpu_if.wdata       = wdata;
        ok    = 1'b0;
        guard = 0;
        while (!ok && guard < 20) begin
            @(negedge clk);
            guard++;
            if (cpu_if.ready) ok = 1'b1;
        end
        if (!ok) begin
            chk("ready_timeout", {31'b0, cpu_if.ready}, 32'd1);
            cpu_if.valid = 1'b0;
            return;
        end
        n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        r.err  = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                 (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= NBYTES);
        r.load = !wr;
        r.due  = cycle + (r.err ? 1 : (wr ? 2 : 3));
        r.rdata = '0;
        if (!r.err) begin
            base   = int'(addr);
            a.addr = addr[AW+1:2];
            a.we   = '0;
            a.data = '0;
            if (wr) begin
                a.data = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
                for (int i = 0; i < n; i++) begin
                    ref_mem[base + i] = wdata[8*i +: 8];
                    a.we[8*((base + i) % 4) +: 8] = 8'hFF;
                end
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
                if (n == 1 && !uns && v[7])  v[31:8]  = '1;
                if (n == 2 && !uns && v[15]) v[31:16] = '1;
                r.rdata = v;
            end
            acc_q.push_back(a);
        end
        resp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        cpu_if.valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        int          sel;
        int          guard;
        cpu_if.valid       = 1'b0;
        cpu_if.wr          = 1'b0;
        cpu_if.size        = 2'b00;
        cpu_if.is_unsigned = 1'b0;
        cpu_if.addr        = '0;
        cpu_if.wdata       = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = sram[i][8*b +: 8];
        end

        // Reset values
        #12;
        chk("rst_ready", {31'b0, cpu_if.ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, cpu_if.resp_valid}, 32'd0);
        chk("rst_err", {31'b0, cpu_if.err}, 32'd0);
        chk("rst_rdata", cpu_if.rdata, 32'd0);
        chk("rst_sram_cs", {31'b0, sram_cs}, 32'd0);
        chk("rst_sram_we", sram_we, 32'd0);
        chk("rst_sram_data", sram_wdata, 32'd0);
        chk("rst_sram_addr", {{(32-AW){1'b0}}, sram_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Word, byte and halfword traffic over one word
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF); idle(1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);        idle(1);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080); idle(1);
        issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        idle(1);

        // Error cases
        issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234);
        issue(1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'h55);
        idle(2);

        // Reset in the middle of a word store to 0x20
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D); idle(2);
        cpu_if.valid = 1'b1;
        cpu_if.wr    = 1'b1;
        cpu_if.size  = 2'd2;
        cpu_if.addr  = 32'h20;
        cpu_if.wdata = 32'h12345678;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!cpu_if.ready && guard < 20);
        chk("mid_rst_ready", {31'b0, cpu_if.ready}, 32'd1);
        @(posedge clk);
        #2;
        chk("mid_rst_cs_before", {31'b0, sram_cs}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_drop", {31'b0, sram_cs}, 32'd0);
        chk("mid_rst_we_drop", sram_we, 32'd0);
        chk("mid_rst_ready_back", {31'b0, cpu_if.ready}, 32'd1);
        cpu_if.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        idle(1);

        // Randomised mix, back to back or with gaps
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      ra = 32'h1000 + $urandom_range(0, 255);
            else if (sel == 1) ra = $urandom;
            else               ra = $urandom_range(0, 127);
            rs = ($urandom_range(0, 15) == 15) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        guard = 0;
        while ((resp_q.size() != 0 || acc_q.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        chk("resp_queue_drained", resp_q.size(), 32'd0);
        chk("access_queue_drained", acc_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
